// File: rtl/pc_pkg.sv
// Shared encodings and default vectors for the program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0040_0004;
  localparam int          DEF_STEP      = 4;

  // Word-alignment check on the two low address bits.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target selection and JR alignment check.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = DEF_STEP
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] br_off,
  input  logic [25:0]      j_idx,
  input  logic [WIDTH-1:0] jr_addr,
  output logic [WIDTH-1:0] target,
  output logic             misaligned
);

  logic [WIDTH-1:0] seq_s;

  assign seq_s = pc + WIDTH'(STEP);

  // Target mux; only a JR source can be misaligned.
  always_comb begin
    target     = seq_s;
    misaligned = 1'b0;
    case (sel)
      SEL_SEQ: target = seq_s;
      SEL_BR:  target = seq_s + (br_off << 2);
      SEL_J:   target = {seq_s[WIDTH-1:28], j_idx, 2'b00};
      SEL_JR: begin
        target     = jr_addr;
        misaligned = is_misaligned(jr_addr[1:0]);
      end
      default: begin
        target     = seq_s;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with stall hold, buffered redirects during
// stalls, exception vectoring with EPC capture, ERET and JR alignment traps.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               STEP      = DEF_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] br_off,
  input  logic [25:0]      j_idx,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             exc_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             misalign,
  output logic             redirect_pending
);

  logic [WIDTH-1:0] pc_r, epc_r, pend_tgt_r;
  logic             pend_v_r, pend_jr_r, misalign_r;

  logic [WIDTH-1:0] target_s;
  logic             tgt_mis_s;

  logic [WIDTH-1:0] pc_nxt_s, epc_nxt_s, pend_tgt_nxt_s;
  logic             pend_v_nxt_s, pend_jr_nxt_s, misalign_nxt_s;

  pc_target_calc #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_calc (
    .pc         (pc_r),
    .sel        (sel),
    .br_off     (br_off),
    .j_idx      (j_idx),
    .jr_addr    (jr_addr),
    .target     (target_s),
    .misaligned (tgt_mis_s)
  );

  // Next-state priority: exc_req > eret > misaligned JR > stall > pending > sel.
  always_comb begin
    pc_nxt_s       = pc_r;
    epc_nxt_s      = epc_r;
    pend_tgt_nxt_s = pend_tgt_r;
    pend_v_nxt_s   = pend_v_r;
    pend_jr_nxt_s  = pend_jr_r;
    misalign_nxt_s = 1'b0;
    if (exc_req) begin
      epc_nxt_s    = pc_r;
      pc_nxt_s     = EXC_VEC;
      pend_v_nxt_s = 1'b0;
    end else if (eret) begin
      pc_nxt_s     = epc_r;
      pend_v_nxt_s = 1'b0;
    end else if (!stall && tgt_mis_s) begin
      epc_nxt_s      = pc_r;
      pc_nxt_s       = EXC_VEC;
      pend_v_nxt_s   = 1'b0;
      misalign_nxt_s = 1'b1;
    end else if (stall) begin
      // Latest non-sequential request during a stall overwrites the buffer.
      if (sel != SEL_SEQ) begin
        pend_tgt_nxt_s = target_s;
        pend_jr_nxt_s  = (sel == SEL_JR);
        pend_v_nxt_s   = 1'b1;
      end else begin
        pend_v_nxt_s   = pend_v_r;
      end
    end else if (pend_v_r) begin
      pend_v_nxt_s = 1'b0;
      if (pend_jr_r && is_misaligned(pend_tgt_r[1:0])) begin
        epc_nxt_s      = pc_r;
        pc_nxt_s       = EXC_VEC;
        misalign_nxt_s = 1'b1;
      end else begin
        pc_nxt_s       = pend_tgt_r;
      end
    end else begin
      pc_nxt_s = target_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= RESET_VEC;
      epc_r      <= '0;
      pend_tgt_r <= '0;
      pend_v_r   <= 1'b0;
      pend_jr_r  <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      pc_r       <= pc_nxt_s;
      epc_r      <= epc_nxt_s;
      pend_tgt_r <= pend_tgt_nxt_s;
      pend_v_r   <= pend_v_nxt_s;
      pend_jr_r  <= pend_jr_nxt_s;
      misalign_r <= misalign_nxt_s;
    end
  end

  assign pc               = pc_r;
  assign pc_plus4         = pc_r + WIDTH'(STEP);
  assign epc              = epc_r;
  assign misalign         = misalign_r;
  assign redirect_pending = pend_v_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, exc_req, eret;
  logic [1:0]  sel;
  logic [31:0] br_off, jr_addr;
  logic [25:0] j_idx;
  logic [31:0] pc, pc_plus4, epc;
  logic        misalign, redirect_pending;

  int checks = 0;
  int failures = 0;

  pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .sel              (sel),
    .br_off           (br_off),
    .j_idx            (j_idx),
    .jr_addr          (jr_addr),
    .exc_req          (exc_req),
    .eret             (eret),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .epc              (epc),
    .misalign         (misalign),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; exc_req = 1'b0; eret = 1'b0;
    sel = 2'd0; br_off = 32'h0; jr_addr = 32'h0; j_idx = 26'h0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_pend", {31'h0, redirect_pending}, 32'h0);
    chk("rst_mis", {31'h0, misalign}, 32'h0);
    chk("rst_plus4", pc_plus4, 32'h0040_0004);

    tick(); chk("seq1", pc, 32'h0040_0004);
    tick(); chk("seq2", pc, 32'h0040_0008);
    tick(); chk("seq3", pc, 32'h0040_000C);
    tick(); chk("seq4", pc, 32'h0040_0010);

    sel = 2'd1; br_off = 32'hFFFF_FFFE;
    tick(); chk("br_back", pc, 32'h0040_000C);
    sel = 2'd2; j_idx = 26'h010_0040;
    tick(); chk("jump", pc, 32'h0040_0100);

    // Stall for three cycles with a JR request, then release with SEQ.
    stall = 1'b1; sel = 2'd3; jr_addr = 32'h0040_0200;
    tick(); chk("stall1_pc", pc, 32'h0040_0100);
    chk("stall1_pend", {31'h0, redirect_pending}, 32'h1);
    tick(); chk("stall2_pc", pc, 32'h0040_0100);
    tick(); chk("stall3_pc", pc, 32'h0040_0100);
    chk("stall3_pend", {31'h0, redirect_pending}, 32'h1);
    stall = 1'b0; sel = 2'd0;
    tick(); chk("release_pc", pc, 32'h0040_0200);
    chk("release_pend", {31'h0, redirect_pending}, 32'h0);
    tick(); chk("after_rel", pc, 32'h0040_0204);

    // Latest-wins overwrite of the pending buffer.
    stall = 1'b1; sel = 2'd3; jr_addr = 32'h0040_0300;
    tick();
    sel = 2'd3; jr_addr = 32'h0040_0020;
    tick();
    sel = 2'd0;
    tick(); chk("ovr_hold", pc, 32'h0040_0204);
    stall = 1'b0; sel = 2'd2; j_idx = 26'h0;
    tick(); chk("latest_wins", pc, 32'h0040_0020);

    // Exception during a stall with a pending redirect.
    stall = 1'b1; sel = 2'd1; br_off = 32'h10;
    tick(); chk("pre_exc_pend", {31'h0, redirect_pending}, 32'h1);
    exc_req = 1'b1;
    tick(); chk("exc_pc", pc, 32'h0040_0004);
    chk("exc_epc", epc, 32'h0040_0020);
    chk("exc_pend", {31'h0, redirect_pending}, 32'h0);
    chk("exc_nomis", {31'h0, misalign}, 32'h0);
    idle();
    tick(); chk("exc_seq", pc, 32'h0040_0008);
    eret = 1'b1;
    tick(); chk("eret_pc", pc, 32'h0040_0020);
    idle();

    // Misaligned JR trap and one-cycle pulse.
    sel = 2'd3; jr_addr = 32'h0040_0302;
    tick(); chk("mis_pc", pc, 32'h0040_0004);
    chk("mis_epc", epc, 32'h0040_0020);
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    idle();
    tick(); chk("mis_drop", {31'h0, misalign}, 32'h0);
    chk("mis_next", pc, 32'h0040_0008);

    // Misaligned JR buffered during stall, trapped on release.
    stall = 1'b1; sel = 2'd3; jr_addr = 32'h0040_0501;
    tick(); chk("bufmis_hold", pc, 32'h0040_0008);
    chk("bufmis_nopulse", {31'h0, misalign}, 32'h0);
    stall = 1'b0; sel = 2'd0;
    tick(); chk("bufmis_pc", pc, 32'h0040_0004);
    chk("bufmis_epc", epc, 32'h0040_0008);
    chk("bufmis_pulse", {31'h0, misalign}, 32'h1);

    // exc_req and eret together: exception wins.
    idle();
    tick(); chk("pre_both", pc, 32'h0040_0008);
    exc_req = 1'b1; eret = 1'b1;
    tick(); chk("both_pc", pc, 32'h0040_0004);
    chk("both_epc", epc, 32'h0040_0008);
    idle();

    // Wrap at the top of the address space.
    sel = 2'd3; jr_addr = 32'hFFFF_FFFC;
    tick(); chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_plus4", pc_plus4, 32'h0);
    sel = 2'd0;
    tick(); chk("wrap_pc", pc, 32'h0);

    // Reset asserted mid-stall with a pending redirect.
    stall = 1'b1; sel = 2'd1; br_off = 32'h40;
    tick(); chk("rst2_pend_set", {31'h0, redirect_pending}, 32'h1);
    reset = 1'b1;
    tick(); chk("rst2_pc", pc, 32'h0040_0000);
    chk("rst2_pend", {31'h0, redirect_pending}, 32'h0);
    chk("rst2_epc", epc, 32'h0);
    idle();
    tick(); chk("rst2_seq", pc, 32'h0040_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
